// File: rtl/pll_clk_reset_seq.sv
// PLL reset/lock sequencer with stretched system reset and clock-enable strobes.
// Optional WAIT-state lock timeout with PLL retry: define LOCK_TIMEOUT_EN.
module pll_clk_reset_seq #(
  parameter int unsigned NUM_EN = 2,
  parameter int unsigned DIV_W = 8,
  parameter logic [NUM_EN*DIV_W-1:0] DIVS = {8'd25, 8'd4},
  parameter int unsigned PLL_RST_CYC = 16,
  parameter int unsigned LOCK_FILTER = 64,
  parameter int unsigned RST_STRETCH = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              pll_locked,
  output logic              pll_resetb,
  output logic              sys_reset_n,
  output logic              ready,
  output logic [NUM_EN-1:0] clk_en,
  output logic [7:0]        lock_loss_cnt,
  output logic [7:0]        retry_cnt
);

  localparam int unsigned M1 =
    (PLL_RST_CYC > LOCK_FILTER) ? PLL_RST_CYC : LOCK_FILTER;
  localparam int unsigned M2 =
    (RST_STRETCH > LOCK_TIMEOUT) ? RST_STRETCH : LOCK_TIMEOUT;
  localparam int unsigned MAXC = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RST_END = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] FLT_END = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] STR_END = CW'(RST_STRETCH - 1);
`ifdef LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_END = CW'(LOCK_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_FILTER,
    S_STRETCH,
    S_RUN
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] loss_q, loss_d;
  logic sync_q, lock_s;

`ifdef LOCK_TIMEOUT_EN
  logic [7:0] retry_q, retry_d;
  assign retry_cnt = retry_q;
`else
  assign retry_cnt = '0;
`endif

  assign lock_loss_cnt = loss_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
`ifdef LOCK_TIMEOUT_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      S_PLLRST: begin
        if (cnt_q == RST_END) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (lock_s) begin
          state_d = S_FILTER;
          cnt_d   = '0;
        end
`ifdef LOCK_TIMEOUT_EN
        else if (cnt_q == TMO_END) begin
          state_d = S_PLLRST;
          cnt_d   = '0;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_FILTER: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == FLT_END) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STRETCH: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == STR_END) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      default: begin
        state_d = S_PLLRST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next state so they line up with state_q.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      sync_q      <= 1'b0;
      lock_s      <= 1'b0;
      state_q     <= S_PLLRST;
      cnt_q       <= '0;
      loss_q      <= '0;
      pll_resetb  <= 1'b0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
      retry_q     <= '0;
`endif
    end else begin
      sync_q      <= pll_locked;
      lock_s      <= sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      pll_resetb  <= (state_d != S_PLLRST);
      sys_reset_n <= (state_d == S_RUN);
      ready       <= (state_d == S_RUN);
`ifdef LOCK_TIMEOUT_EN
      retry_q     <= retry_d;
`endif
    end
  end

  for (genvar i = 0; i < NUM_EN; i++) begin : g_en
    localparam logic [DIV_W-1:0] DIV_RAW = DIVS[i*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] DIV_END =
      (DIV_RAW == '0) ? '0 : DIV_RAW - 1'b1;

    logic [DIV_W-1:0] ecnt_q, ecnt_d;
    logic en_q;

    // Counter restarts at zero on every RUN entry.
    always_comb begin
      ecnt_d = '0;
      if (state_q == S_RUN && state_d == S_RUN)
        ecnt_d = (ecnt_q == DIV_END) ? '0 : ecnt_q + 1'b1;
    end

    always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
        ecnt_q <= '0;
        en_q   <= 1'b0;
      end else begin
        ecnt_q <= ecnt_d;
        en_q   <= (state_d == S_RUN) && (ecnt_d == DIV_END);
      end
    end

    assign clk_en[i] = en_q;
  end

endmodule
